// File: rtl/uart_term_writer.sv
// uart_term_writer: terminal sink for received UART bytes. Printable bytes go
// into a character VRAM at the cursor; CR/LF/BS/FF move the cursor or clear.
// Rows are circular; top_row tells the renderer which row is oldest on screen.
`timescale 1ns/1ps
module uart_term_writer #(
  parameter int          COLS   = 80,
  parameter int          ROWS   = 30,
  parameter int          ADDR_W = 12,
  parameter logic [7:0]  BLANK  = 8'h20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                term_in_tdata,
  input  logic                      term_in_tvalid,
  output logic                      term_in_tready,
  output logic                      vram_we,
  output logic [ADDR_W-1:0]         vram_addr,
  output logic [7:0]                vram_wdata,
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic [$clog2(ROWS)-1:0]   cursor_row,
  output logic [$clog2(ROWS)-1:0]   top_row
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS*ROWS-1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_CIDX = ADDR_W'(COLS-1);
  localparam logic [CW-1:0]     LAST_COL  = CW'(COLS-1);
  localparam logic [RW-1:0]     LAST_ROW  = RW'(ROWS-1);

  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_LINE} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       col, col_n;
  logic [RW-1:0]       row, row_n, top, top_n;
  logic [ADDR_W-1:0]   row_base, row_base_n, clr_idx, clr_idx_n;
  logic                full, full_n;
  logic                we_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [7:0]          wdata_n;

  // Values a row advance would produce; row_base tracks row*COLS by addition.
  logic [RW-1:0]       adv_row, adv_top;
  logic [ADDR_W-1:0]   adv_base;
  logic                adv_full;

  assign term_in_tready = (state == IDLE);
  assign cursor_col     = col;
  assign cursor_row     = row;
  assign top_row        = top;

  // Row-advance arithmetic: wrap row and row_base together, latch full on wrap.
  always_comb begin
    adv_row  = (row == LAST_ROW) ? '0 : row + RW'(1);
    adv_base = (row == LAST_ROW) ? '0 : row_base + COLS_A;
    adv_full = full | (row == LAST_ROW);
    adv_top  = '0;
    if (adv_full) adv_top = (adv_row == LAST_ROW) ? '0 : adv_row + RW'(1);
  end

  // Next-state and registered-output decode for clears and byte handling.
  always_comb begin
    state_n    = state;
    col_n      = col;
    row_n      = row;
    top_n      = top;
    row_base_n = row_base;
    full_n     = full;
    clr_idx_n  = clr_idx;
    we_n       = 1'b0;
    addr_n     = vram_addr;
    wdata_n    = vram_wdata;
    case (state)
      CLR_ALL: begin
        we_n    = 1'b1;
        addr_n  = clr_idx;
        wdata_n = BLANK;
        if (clr_idx == LAST_ADDR) begin
          clr_idx_n = '0;
          state_n   = IDLE;
        end else begin
          clr_idx_n = clr_idx + ADDR_W'(1);
        end
      end
      CLR_LINE: begin
        we_n    = 1'b1;
        addr_n  = row_base + clr_idx;
        wdata_n = BLANK;
        if (clr_idx == LAST_CIDX) begin
          clr_idx_n = '0;
          state_n   = IDLE;
        end else begin
          clr_idx_n = clr_idx + ADDR_W'(1);
        end
      end
      default: begin
        if (term_in_tvalid) begin
          if (term_in_tdata >= 8'h20 && term_in_tdata <= 8'h7E) begin
            we_n    = 1'b1;
            addr_n  = row_base + ADDR_W'(col);
            wdata_n = term_in_tdata;
            if (col == LAST_COL) begin
              col_n      = '0;
              row_n      = adv_row;
              row_base_n = adv_base;
              full_n     = adv_full;
              top_n      = adv_top;
              clr_idx_n  = '0;
              state_n    = CLR_LINE;
            end else begin
              col_n = col + CW'(1);
            end
          end else if (term_in_tdata == 8'h0D) begin
            col_n = '0;
          end else if (term_in_tdata == 8'h0A) begin
            col_n      = '0;
            row_n      = adv_row;
            row_base_n = adv_base;
            full_n     = adv_full;
            top_n      = adv_top;
            clr_idx_n  = '0;
            state_n    = CLR_LINE;
          end else if (term_in_tdata == 8'h08) begin
            if (col != '0) begin
              col_n   = col - CW'(1);
              we_n    = 1'b1;
              addr_n  = row_base + ADDR_W'(col - CW'(1));
              wdata_n = BLANK;
            end
          end else if (term_in_tdata == 8'h0C) begin
            col_n      = '0;
            row_n      = '0;
            row_base_n = '0;
            full_n     = 1'b0;
            top_n      = '0;
            clr_idx_n  = '0;
            state_n    = CLR_ALL;
          end
        end
      end
    endcase
  end

  // State register; reset always restarts with a full-screen clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLR_ALL;
      col        <= '0;
      row        <= '0;
      top        <= '0;
      row_base   <= '0;
      full       <= 1'b0;
      clr_idx    <= '0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= '0;
    end else begin
      state      <= state_n;
      col        <= col_n;
      row        <= row_n;
      top        <= top_n;
      row_base   <= row_base_n;
      full       <= full_n;
      clr_idx    <= clr_idx_n;
      vram_we    <= we_n;
      vram_addr  <= addr_n;
      vram_wdata <= wdata_n;
    end
  end
endmodule

// File: tb/tb_uart_term_writer.sv
// Bench for uart_term_writer: a full-size 80x30 instance and a 4x3 instance.
// Expected VRAM writes are queued when bytes are driven and popped by a
// negedge monitor; cursor/top_row checks follow each accepted byte.
`timescale 1ns/1ps
module tb_uart_term_writer;
  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic [7:0]  td0, td1;
  logic        tv0, tv1;
  logic        tr0, tr1, we0, we1;
  logic [11:0] a0;
  logic [3:0]  a1;
  logic [7:0]  wd0, wd1;
  logic [6:0]  c0;
  logic [4:0]  r0, t0;
  logic [1:0]  c1, r1, t1;

  always #5 clk = ~clk;

  uart_term_writer #(.COLS(80), .ROWS(30), .ADDR_W(12), .BLANK(8'h20)) dut0 (
    .clk(clk), .rst(rst0), .term_in_tdata(td0), .term_in_tvalid(tv0),
    .term_in_tready(tr0), .vram_we(we0), .vram_addr(a0), .vram_wdata(wd0),
    .cursor_col(c0), .cursor_row(r0), .top_row(t0));

  uart_term_writer #(.COLS(4), .ROWS(3), .ADDR_W(4), .BLANK(8'h20)) dut1 (
    .clk(clk), .rst(rst1), .term_in_tdata(td1), .term_in_tvalid(tv1),
    .term_in_tready(tr1), .vram_we(we1), .vram_addr(a1), .vram_wdata(wd1),
    .cursor_col(c1), .cursor_row(r1), .top_row(t1));

  typedef struct { int addr; int data; } wr_t;
  typedef struct { logic [7:0] b; bit wr; int addr; int data; int clr; int col; int row; int top; } vec_t;

  wr_t q0[$], q1[$];
  wr_t em;
  int  cmp = 0, err = 0, cyc = 0;
  int  last0 = 0, prev0 = 0;

  // Write monitor: every VRAM write must match the head of its queue.
  always @(negedge clk) begin
    cyc++;
    if (we0) begin
      cmp++;
      if (q0.size() == 0) begin
        err++; $display("FAIL wr0 unexpected: got addr=%0d data=%h", a0, wd0);
      end else begin
        em = q0.pop_front();
        if (em.addr != int'(a0) || em.data != int'(wd0)) begin
          err++;
          $display("FAIL wr0: got addr=%0d data=%h expected addr=%0d data=%h", a0, wd0, em.addr, em.data);
        end
      end
      prev0 = last0; last0 = cyc;
    end
    if (we1) begin
      cmp++;
      if (q1.size() == 0) begin
        err++; $display("FAIL wr1 unexpected: got addr=%0d data=%h", a1, wd1);
      end else begin
        em = q1.pop_front();
        if (em.addr != int'(a1) || em.data != int'(wd1)) begin
          err++;
          $display("FAIL wr1: got addr=%0d data=%h expected addr=%0d data=%h", a1, wd1, em.addr, em.data);
        end
      end
    end
  end

  task automatic nedge; @(negedge clk); #1; endtask

  task automatic chk(input string nm, input int act, input int exp);
    cmp++;
    if (act != exp) begin
      err++; $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic rdy(input int s);
    return (s == 0) ? tr0 : tr1;
  endfunction

  task automatic push(input int s, input int addr, input int data);
    wr_t w;
    w.addr = addr; w.data = data;
    if (s == 0) q0.push_back(w); else q1.push_back(w);
  endtask

  task automatic push_clr(input int s, input int base, input int n);
    for (int i = 0; i < n; i++) push(s, base + i, 8'h20);
  endtask

  task automatic wait_rdy(input int s, input int lim, output int n);
    n = 0;
    while (!rdy(s) && n < lim) begin nedge(); n++; end
    if (!rdy(s)) begin
      cmp++; err++; $display("FAIL tready timeout dut%0d after %0d cycles", s, n);
    end
  endtask

  // Present a byte and return on the negedge after it is accepted; tvalid stays up.
  task automatic send(input int s, input logic [7:0] b, output int waited);
    if (s == 0) begin td0 = b; tv0 = 1'b1; end else begin td1 = b; tv1 = 1'b1; end
    wait_rdy(s, 5000, waited);
    nedge();
  endtask

  task automatic idle(input int s);
    if (s == 0) tv0 = 1'b0; else tv1 = 1'b0;
  endtask

  vec_t tbl[12];
  int   n;
  int   lf_row[4] = '{1, 2, 0, 1};
  int   lf_top[4] = '{0, 0, 1, 2};

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; tv0 = 1'b0; tv1 = 1'b0; td0 = 8'h00; td1 = 8'h00;
    // Vectors on the 80x30 instance, starting at col 2 row 0 after "AB".
    tbl[0]  = '{8'h58, 1, 2,  8'h58, -1, 3, 0, 0};
    tbl[1]  = '{8'h0D, 0, 0,  0,     -1, 0, 0, 0};
    tbl[2]  = '{8'h59, 1, 0,  8'h59, -1, 1, 0, 0};
    tbl[3]  = '{8'h08, 1, 0,  8'h20, -1, 0, 0, 0};
    tbl[4]  = '{8'h08, 0, 0,  0,     -1, 0, 0, 0};
    tbl[5]  = '{8'h01, 0, 0,  0,     -1, 0, 0, 0};
    tbl[6]  = '{8'h7E, 1, 0,  8'h7E, -1, 1, 0, 0};
    tbl[7]  = '{8'h7F, 0, 0,  0,     -1, 1, 0, 0};
    tbl[8]  = '{8'h20, 1, 1,  8'h20, -1, 2, 0, 0};
    tbl[9]  = '{8'h0A, 0, 0,  0,     80, 0, 1, 0};
    tbl[10] = '{8'h51, 1, 80, 8'h51, -1, 1, 1, 0};
    tbl[11] = '{8'h1F, 0, 0,  0,     -1, 1, 1, 0};

    // T1: reset values, then full-screen clear on both instances
    repeat (3) nedge();
    chk("rst we0", int'(we0), 0); chk("rst tready0", int'(tr0), 0);
    chk("rst col0", int'(c0), 0); chk("rst row0", int'(r0), 0); chk("rst top0", int'(t0), 0);
    chk("rst we1", int'(we1), 0); chk("rst tready1", int'(tr1), 0);
    push_clr(0, 0, 2400); push_clr(1, 0, 12);
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (1000) nedge();
    chk("clr_all tready0 low", int'(tr0), 0);
    wait_rdy(0, 3000, n);
    chk("clr_all writes left0", q0.size(), 0);
    chk("post clr col0", int'(c0), 0); chk("post clr row0", int'(r0), 0);
    chk("post clr top0", int'(t0), 0);

    // T2: back-to-back "AB"
    push(0, 0, 8'h41); send(0, 8'h41, n);
    push(0, 1, 8'h42); send(0, 8'h42, n);
    chk("AB tready held", int'(tr0), 1);
    idle(0);
    chk("AB col", int'(c0), 2);
    chk("AB consecutive writes", last0 - prev0, 1);

    // T3 and byte decode: table vectors
    foreach (tbl[i]) begin
      if (tbl[i].wr) push(0, tbl[i].addr, tbl[i].data);
      if (tbl[i].clr >= 0) push_clr(0, tbl[i].clr, 80);
      send(0, tbl[i].b, n);
      idle(0);
      chk($sformatf("vec%0d col", i), int'(c0), tbl[i].col);
      chk($sformatf("vec%0d row", i), int'(r0), tbl[i].row);
      chk($sformatf("vec%0d top", i), int'(t0), tbl[i].top);
    end

    // T4: 4x3 auto-wrap at the last column
    wait_rdy(1, 100, n);
    push(1, 0, 8'h61); push(1, 1, 8'h62); push(1, 2, 8'h63); push(1, 3, 8'h64);
    push_clr(1, 4, 4);
    send(1, 8'h61, n); send(1, 8'h62, n); send(1, 8'h63, n); send(1, 8'h64, n);
    idle(1);
    chk("wrap col", int'(c1), 0); chk("wrap row", int'(r1), 1);
    wait_rdy(1, 100, n);
    chk("wrap clr_line cycles", n, 4);
    chk("wrap writes left", q1.size(), 0);

    // FF back to the top of the screen before the row-wrap test
    push_clr(1, 0, 12);
    send(1, 8'h0C, n); idle(1);
    chk("FF col", int'(c1), 0); chk("FF row", int'(r1), 0); chk("FF top", int'(t1), 0);
    wait_rdy(1, 100, n);

    // T5: four LFs walk the circular rows and set top_row once full
    for (int k = 0; k < 4; k++) begin
      push_clr(1, lf_row[k] * 4, 4);
      send(1, 8'h0A, n); idle(1);
      chk($sformatf("lf%0d row", k), int'(r1), lf_row[k]);
      chk($sformatf("lf%0d top", k), int'(t1), lf_top[k]);
      wait_rdy(1, 100, n);
    end
    chk("lf writes left", q1.size(), 0);

    // T6: FF mid-line with 'Z' held behind it
    push(1, 4, 8'h71); send(1, 8'h71, n);
    push_clr(1, 0, 12); send(1, 8'h0C, n);
    push(1, 0, 8'h5A); send(1, 8'h5A, n);
    idle(1);
    chk("FF stall cycles", n, 12);
    chk("Z col", int'(c1), 1); chk("Z row", int'(r1), 0); chk("Z top", int'(t1), 0);

    // T7: reset during a line clear restarts with a full clear
    push_clr(1, 4, 4);
    send(1, 8'h0A, n); idle(1);
    nedge(); nedge();
    rst1 = 1'b1;
    q1.delete();
    nedge();
    chk("rst mid clr we", int'(we1), 0);
    chk("rst mid clr row", int'(r1), 0);
    push_clr(1, 0, 12);
    rst1 = 1'b0;
    wait_rdy(1, 100, n);
    chk("rst restart cycles", n, 12);
    chk("rst restart col", int'(c1), 0);

    repeat (5) nedge();
    chk("final left0", q0.size(), 0);
    chk("final left1", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
